// File: rtl/instr_cache_dm.sv
// Direct-mapped instruction cache with word-by-word refill from backing memory.
// Hits respond the cycle after acceptance; misses refill the whole line, then
// deliver the requested word in a single RESPOND cycle.
module instr_cache_dm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REFILL  = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  // Storage: data/tag contents are only meaningful while the line's valid bit is set
  logic [DATA_W-1:0] r_data_mem [LINES*WORDS];
  logic [TAG_W-1:0]  r_tag_mem  [LINES];
  logic [LINES-1:0]  r_valid;

  logic [1:0]        r_state;
  logic [OFF_W-1:0]  r_word_ctr;
  logic              r_flush_pend;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic [DATA_W-1:0] r_fill_word;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [OFF_W-1:0]  r_off;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic [OFF_W-1:0]       w_off;
  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic                   w_fill_we;
  logic                   w_fill_last;
  logic [IDX_W+OFF_W-1:0] w_fill_addr;
  logic                   w_unused_addr_lsb;

  assign w_off             = req_addr[OFF_W+1:2];
  assign w_idx             = req_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag             = req_addr[ADDR_W-1:OFF_W+IDX_W+2];
  assign w_unused_addr_lsb = ^req_addr[1:0];
  assign w_hit             = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
  assign w_fill_we         = (r_state == S_REFILL) && mem_ack;
  assign w_fill_last       = w_fill_we && (r_word_ctr == OFF_W'(WORDS - 1));
  assign w_fill_addr       = {r_idx, r_word_ctr};

  assign req_ready  = (r_state == S_IDLE) && !flush;
  assign mem_req    = (r_state == S_REFILL);
  assign mem_addr   = {r_tag, r_idx, r_word_ctr, 2'b00};
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

  // Refill writes into the data and tag arrays (not reset; guarded by valid bits)
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data_mem[w_fill_addr] <= mem_rdata;
    end
    if (w_fill_last) begin
      r_tag_mem[r_idx] <= r_tag;
    end
  end

  // Controller: lookup, refill sequencing, response and flush handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_word_ctr   <= '0;
      r_flush_pend <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_fill_word  <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_off        <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state <= S_FLUSH;
          end else if (req_valid) begin
            if (w_hit) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= r_data_mem[{w_idx, w_off}];
            end else begin
              r_tag          <= w_tag;
              r_idx          <= w_idx;
              r_off          <= w_off;
              r_valid[w_idx] <= 1'b0;
              r_word_ctr     <= '0;
              r_state        <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (mem_ack) begin
            // Keep the requested word aside so RESPOND needs no array read
            if (r_word_ctr == r_off) begin
              r_fill_word <= mem_rdata;
            end
            r_word_ctr <= r_word_ctr + 1'b1;
            if (w_fill_last) begin
              r_valid[r_idx] <= 1'b1;
              r_resp_valid   <= 1'b1;
              r_resp_data    <= (r_off == r_word_ctr) ? mem_rdata : r_fill_word;
              r_word_ctr     <= '0;
              r_state        <= S_RESPOND;
            end
          end
        end
        S_RESPOND: begin
          r_flush_pend <= 1'b0;
          r_state      <= (r_flush_pend || flush) ? S_FLUSH : S_IDLE;
        end
        default: begin
          r_valid <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating hit/miss counters, stepped on accepted requests in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if ((r_state == S_IDLE) && !flush && req_valid) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

endmodule
